// File: rtl/seq_controller_if.sv
// Control bundle between the Y86 sequencer and its fetch/decode/execute/memory datapath.
// The master side is the sequencer: it consumes status inputs and drives stage enables.
interface seq_controller_if;
  logic        start;
  logic [3:0]  icode;
  logic        instr_err;
  logic        mem_error;
  logic        mem_ack;

  logic        en_fetch;
  logic        en_decode;
  logic        en_execute;
  logic        en_memory;
  logic        en_wb;
  logic        en_pc;
  logic        mem_req;
  logic        cc_we;
  logic [2:0]  stat;
  logic        busy;
  logic [31:0] instr_count;

  modport master (
    input  start, icode, instr_err, mem_error, mem_ack,
    output en_fetch, en_decode, en_execute, en_memory, en_wb, en_pc,
    output mem_req, cc_we, stat, busy, instr_count
  );

  modport slave (
    output start, icode, instr_err, mem_error, mem_ack,
    input  en_fetch, en_decode, en_execute, en_memory, en_wb, en_pc,
    input  mem_req, cc_we, stat, busy, instr_count
  );
endinterface

// File: rtl/seq_controller.sv
// Multi-cycle Y86 sequencer: FETCH..PCUPD, 6 cycles per instruction plus memory ack wait.
// Backpressure only via mem_ack in MEMORY, bounded by MEM_TIMEOUT; HALT/ERROR absorb until rst.
module seq_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  seq_controller_if.master  bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    MEMORY,
    WB,
    PCUPD,
    HALT,
    ERROR
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [2:0]          stat_q;
  logic [2:0]          stat_nxt;
  logic [3:0]          icode_q;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [31:0]         instr_count_q;
  logic                mem_op;
  logic                wait_last;

  // Loads, stores, push and pop touch data memory; everything else skips the handshake.
  always_comb begin
    mem_op = 1'b0;
    case (icode_q)
      4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: mem_op = 1'b1;
      default:                            mem_op = 1'b0;
    endcase
  end

  assign wait_last = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    stat_nxt  = stat_q;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = FETCH;
      end
      FETCH: begin
        if (bus.instr_err) begin
          state_nxt = ERROR;
          stat_nxt  = STAT_INS;
        end else if (bus.mem_error) begin
          state_nxt = ERROR;
          stat_nxt  = STAT_ADR;
        end else begin
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        if (bus.icode == 4'h0) begin
          state_nxt = HALT;
          stat_nxt  = STAT_HLT;
        end else if (bus.icode > 4'hB) begin
          state_nxt = ERROR;
          stat_nxt  = STAT_INS;
        end else begin
          state_nxt = EXECUTE;
        end
      end
      EXECUTE: state_nxt = MEMORY;
      MEMORY: begin
        if (!mem_op) begin
          state_nxt = WB;
        end else if (bus.mem_error) begin
          state_nxt = ERROR;
          stat_nxt  = STAT_ADR;
        end else if (bus.mem_ack) begin
          state_nxt = WB;
        end else if (wait_last) begin
          state_nxt = ERROR;
          stat_nxt  = STAT_ADR;
        end
      end
      WB:      state_nxt = PCUPD;
      PCUPD:   state_nxt = FETCH;
      HALT:    state_nxt = HALT;
      ERROR:   state_nxt = ERROR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      stat_q        <= STAT_AOK;
      icode_q       <= 4'h0;
      wait_cnt      <= '0;
      instr_count_q <= 32'd0;
    end else begin
      state  <= state_nxt;
      stat_q <= stat_nxt;
      if (state == DECODE) icode_q <= bus.icode;
      // Held at zero outside MEMORY so every entry starts a fresh timeout window.
      if (state == MEMORY) begin
        if (!bus.mem_ack) wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
      if (state == PCUPD) instr_count_q <= instr_count_q + 32'd1;
    end
  end

  always_comb begin
    bus.en_fetch    = 1'b0;
    bus.en_decode   = 1'b0;
    bus.en_execute  = 1'b0;
    bus.en_memory   = 1'b0;
    bus.en_wb       = 1'b0;
    bus.en_pc       = 1'b0;
    bus.mem_req     = 1'b0;
    bus.cc_we       = 1'b0;
    bus.busy        = 1'b0;
    bus.stat        = stat_q;
    bus.instr_count = instr_count_q;
    case (state)
      FETCH: begin
        bus.en_fetch = 1'b1;
        bus.busy     = 1'b1;
      end
      DECODE: begin
        bus.en_decode = 1'b1;
        bus.busy      = 1'b1;
      end
      EXECUTE: begin
        bus.en_execute = 1'b1;
        bus.cc_we      = (icode_q == 4'h6);
        bus.busy       = 1'b1;
      end
      MEMORY: begin
        bus.en_memory = 1'b1;
        bus.mem_req   = mem_op;
        bus.busy      = 1'b1;
      end
      WB: begin
        bus.en_wb = 1'b1;
        bus.busy  = 1'b1;
      end
      PCUPD: begin
        bus.en_pc = 1'b1;
        bus.busy  = 1'b1;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/seq_controller.md
SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 SHALL provide parameter: MEM_TIMEOUT, 16, max cycles MEMORY waits for mem_ack before an address fault.
REQ-002 SHALL provide port: clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL provide port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port: start  input  1  begin execution from IDLE.
REQ-005 SHALL provide port: icode  input  4  instruction code from fetch stage.
REQ-006 SHALL provide port: instr_err  input  1  fetch reports invalid instruction.
REQ-007 SHALL provide port: mem_error  input  1  fetch or data memory reports bad address.
REQ-008 SHALL provide port: mem_ack  input  1  data memory access complete.
REQ-009 SHALL provide ports: en_fetch, en_decode, en_execute, en_memory, en_wb, en_pc  output  1 each  stage enables, asserted only in their own state.
REQ-010 SHALL provide port: mem_req  output  1  data memory request.
REQ-011 SHALL provide port: cc_we  output  1  condition-code write enable.
REQ-012 SHALL provide port: stat  output  3  Y86 status: 1=AOK, 2=HLT, 3=ADR, 4=INS.
REQ-013 SHALL provide ports: busy  output  1  state not IDLE/HALT/ERROR; instr_count  output  32  retired instructions.

Function
REQ-014 SHALL implement states IDLE, FETCH, DECODE, EXECUTE, MEMORY, WB, PCUPD, HALT, ERROR; all outputs Moore-decoded from state and registers.
REQ-015 IDLE: start=1 -> FETCH next cycle; start ignored in every other state.
REQ-016 FETCH: instr_err=1 -> ERROR, stat=INS; else mem_error=1 -> ERROR, stat=ADR (instr_err wins when both); else -> DECODE.
REQ-017 DECODE: SHALL latch icode into icode_q; icode=0 -> HALT, stat=HLT; icode>4'hB -> ERROR, stat=INS; else -> EXECUTE.
REQ-018 EXECUTE: cc_we=1 for exactly this cycle iff icode_q=6 (OPq); -> MEMORY.
REQ-019 MEMORY, icode_q in {4,5,8,9,A,B}: mem_req=1 every cycle in state; mem_ack=1 and mem_error=0 -> WB; mem_error=1 (with or without ack) -> ERROR, stat=ADR.
REQ-020 MEMORY timeout: wait counter cleared on entry, +1 per cycle without ack; ack absent for MEM_TIMEOUT consecutive cycles -> ERROR, stat=ADR; ack in cycle MEM_TIMEOUT still completes normally.
REQ-021 MEMORY, other icodes: mem_req=0, mem_ack/mem_error ignored, one cycle -> WB.
REQ-022 WB -> PCUPD; PCUPD: instr_count+1 (wraps 2^32-1 -> 0) -> FETCH.
REQ-023 Latency: non-memory instruction 6 cycles FETCH-to-FETCH; memory instruction 6 + (ack wait cycles).
REQ-024 HALT and ERROR SHALL be absorbing: all enables, mem_req, cc_we, busy = 0; stat and instr_count hold; only rst exits.
REQ-025 A halted or faulting instruction SHALL NOT assert en_wb or en_pc and SHALL NOT increment instr_count.

Reset
REQ-026 rst=1 SHALL override all inputs and, next cycle: state IDLE, all enables/mem_req/cc_we/busy=0, stat=1 (AOK), instr_count=0, wait counter=0, icode_q=0.
REQ-027 rst asserted mid-instruction (incl. MEMORY with mem_req high) SHALL drop mem_req the following cycle; no pending ack is honoured.

Verification
REQ-028 rst, start, icode=6 steady, no errors -> en_* one-hot FETCH..PCUPD over 6 cycles, cc_we=1 only in EXECUTE, instr_count=1, back in FETCH.
REQ-029 icode=5, mem_ack after 3 wait cycles -> mem_req high 4 cycles, WB on cycle after ack, instr_count+1, 9-cycle instruction.
REQ-030 icode=A, mem_ack never -> mem_req high 16 cycles, then ERROR, stat=3, busy=0, instr_count unchanged.
REQ-031 icode=0 after one retired nop -> HALT from DECODE, stat=2, instr_count=1, no en_wb/en_pc for halt; start ignored afterwards.
REQ-032 FETCH with instr_err=1 and mem_error=1 -> ERROR, stat=4; then rst -> IDLE, stat=1, instr_count=0.
REQ-033 rst pulsed while in MEMORY with mem_req=1 and mem_ack=1 same cycle -> IDLE next cycle, mem_req=0, instr_count=0.
